// File: rtl/fft_channel_scheduler_if.sv
// Handshake bundle between the channel FIFO/FFT datapath and the FFT channel scheduler.
// The master modport is the scheduler side; the slave modport is the surrounding datapath.
interface fft_channel_scheduler_if #(
  parameter int NUM_CH = 2
);
  logic              enable;
  logic [NUM_CH-1:0] ch_req;
  logic [NUM_CH-1:0] ch_mask;
  logic              fft_send_done;
  logic              fft_recv_done;
  logic              fft_start;
  logic              fft_abort;
  logic [NUM_CH-1:0] grant;
  logic [1:0]        grant_idx;
  logic              busy;
  logic              frame_done;
  logic              timeout_err;

  modport master (
    input  enable, ch_req, ch_mask, fft_send_done, fft_recv_done,
    output fft_start, fft_abort, grant, grant_idx, busy, frame_done, timeout_err
  );

  modport slave (
    output enable, ch_req, ch_mask, fft_send_done, fft_recv_done,
    input  fft_start, fft_abort, grant, grant_idx, busy, frame_done, timeout_err
  );
endinterface

// File: rtl/fft_channel_scheduler.sv
// Round-robin owner of the shared FFT engine: grant, send, receive, forced gap,
// with a watchdog that aborts frames whose output never completes.
module fft_channel_scheduler #(
  parameter int NUM_CH  = 2,
  parameter int GAP_CYC = 1024,
  parameter int TIMEOUT = 65535,
  parameter int CNT_W   = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  fft_channel_scheduler_if.master sif
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_GRANT = 3'd1,
    S_SEND  = 3'd2,
    S_RECV  = 3'd3,
    S_GAP   = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] WDOG_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYC);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  state_t            state;
  logic [1:0]        last_ch;
  logic [CNT_W-1:0]  wdog_cnt;
  logic [CNT_W-1:0]  gap_cnt;
  logic [NUM_CH-1:0] eligible;
  logic [1:0]        pick;
  logic              wdog_expired;

  // First eligible channel after the previous owner, wrapping modulo NUM_CH.
  function automatic logic [1:0] rr_pick(input logic [NUM_CH-1:0] elig,
                                         input logic [1:0]        last);
    logic [1:0]        sel;
    logic              found;
    logic [NUM_CH-1:0] shifted;
    int                idx;
    sel   = last;
    found = 1'b0;
    for (int k = 1; k <= NUM_CH; k++) begin
      idx     = (int'(last) + k) % NUM_CH;
      shifted = elig >> idx;
      if (!found && shifted[0]) begin
        sel   = 2'(idx);
        found = 1'b1;
      end
    end
    return sel;
  endfunction

  assign eligible = sif.ch_req & sif.ch_mask;
  assign pick     = rr_pick(eligible, last_ch);
  // >= keeps the watchdog armed in RECV even if send_done won the expiry cycle in SEND.
  assign wdog_expired = (wdog_cnt >= WDOG_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= S_IDLE;
      last_ch         <= 2'(NUM_CH - 1);
      wdog_cnt        <= '0;
      gap_cnt         <= '0;
      sif.fft_start   <= 1'b0;
      sif.fft_abort   <= 1'b0;
      sif.grant       <= '0;
      sif.grant_idx   <= 2'd0;
      sif.busy        <= 1'b0;
      sif.frame_done  <= 1'b0;
      sif.timeout_err <= 1'b0;
    end else begin
      sif.fft_start   <= 1'b0;
      sif.fft_abort   <= 1'b0;
      sif.frame_done  <= 1'b0;
      sif.timeout_err <= 1'b0;

      case (state)
        S_IDLE: begin
          if (sif.enable && (|eligible)) begin
            sif.grant     <= NUM_CH'(1) << pick;
            sif.grant_idx <= pick;
            last_ch       <= pick;
            sif.busy      <= 1'b1;
            state         <= S_GRANT;
          end
        end

        S_GRANT: begin
          sif.fft_start <= 1'b1;
          wdog_cnt      <= '0;
          state         <= S_SEND;
        end

        S_SEND: begin
          if (wdog_cnt != CNT_MAX) wdog_cnt <= wdog_cnt + CNT_W'(1);
          if (sif.fft_send_done) begin
            state <= S_RECV;
          end else if (wdog_expired) begin
            sif.fft_abort   <= 1'b1;
            sif.timeout_err <= 1'b1;
            sif.grant       <= '0;
            gap_cnt         <= GAP_LOAD;
            state           <= S_GAP;
          end
        end

        S_RECV: begin
          if (wdog_cnt != CNT_MAX) wdog_cnt <= wdog_cnt + CNT_W'(1);
          if (sif.fft_recv_done) begin
            sif.frame_done <= 1'b1;
            sif.grant      <= '0;
            gap_cnt        <= GAP_LOAD;
            state          <= S_GAP;
          end else if (wdog_expired) begin
            sif.fft_abort   <= 1'b1;
            sif.timeout_err <= 1'b1;
            sif.grant       <= '0;
            gap_cnt         <= GAP_LOAD;
            state           <= S_GAP;
          end
        end

        S_GAP: begin
          // A load of 0 or 1 both leave GAP after a single cycle.
          if (gap_cnt <= CNT_W'(1)) begin
            sif.busy <= 1'b0;
            state    <= S_IDLE;
          end else begin
            gap_cnt <= gap_cnt - CNT_W'(1);
          end
        end

        default: begin
          sif.grant <= '0;
          sif.busy  <= 1'b0;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fft_channel_scheduler.sv
// Directed bench for fft_channel_scheduler: latency, round-robin order, masking,
// watchdog abort, done-wins-expiry, enable gating and asynchronous reset.
module tb_fft_channel_scheduler;

  localparam int NUM_CH  = 2;
  localparam int GAP_CYC = 4;
  localparam int TIMEOUT = 100;
  localparam int CNT_W   = 16;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;

  fft_channel_scheduler_if #(.NUM_CH(NUM_CH)) sif ();

  fft_channel_scheduler #(
    .NUM_CH (NUM_CH),
    .GAP_CYC(GAP_CYC),
    .TIMEOUT(TIMEOUT),
    .CNT_W  (CNT_W)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .sif  (sif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation time limit reached, got hang, required completion");
    $fatal(1, "bench timeout");
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n             = 1'b0;
    sif.enable        = 1'b0;
    sif.ch_req        = '0;
    sif.ch_mask       = '0;
    sif.fft_send_done = 1'b0;
    sif.fft_recv_done = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  task automatic wait_start(input string tag);
    int n;
    n = 0;
    while (!sif.fft_start && n < 20) begin
      tick();
      n++;
    end
    check_eq({tag, "_start"}, 32'(sif.fft_start), 32'd1);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (sif.busy && n < 20) begin
      tick();
      n++;
    end
    check_eq({tag, "_idle"}, 32'(sif.busy), 32'd0);
  endtask

  task automatic run_frame(input logic [1:0] exp_idx, input string tag);
    wait_start(tag);
    check_eq({tag, "_idx"}, 32'(sif.grant_idx), 32'(exp_idx));
    check_eq({tag, "_grant"}, 32'(sif.grant), 32'd1 << exp_idx);
    sif.fft_send_done = 1'b1;
    tick();
    sif.fft_send_done = 1'b0;
    sif.fft_recv_done = 1'b1;
    tick();
    sif.fft_recv_done = 1'b0;
    check_eq({tag, "_fdone"}, 32'(sif.frame_done), 32'd1);
    wait_idle(tag);
  endtask

  initial begin
    int n;
    n_chk  = 0;
    n_fail = 0;

    // Reset values
    rst_n = 1'b0;
    sif.enable = 1'b0; sif.ch_req = '0; sif.ch_mask = '0;
    sif.fft_send_done = 1'b0; sif.fft_recv_done = 1'b0;
    repeat (2) tick();
    check_eq("rst_busy",  32'(sif.busy),      32'd0);
    check_eq("rst_grant", 32'(sif.grant),     32'd0);
    check_eq("rst_idx",   32'(sif.grant_idx), 32'd0);
    check_eq("rst_start", 32'(sif.fft_start), 32'd0);
    check_eq("rst_abort", 32'(sif.fft_abort), 32'd0);
    rst_n = 1'b1;
    tick();

    // Single channel, latency and gap length
    sif.enable = 1'b1; sif.ch_mask = 2'b11; sif.ch_req = 2'b01;
    tick();
    check_eq("t1_busy_grant",  32'(sif.busy),      32'd1);
    check_eq("t1_grant",       32'(sif.grant),     32'd1);
    check_eq("t1_start_early", 32'(sif.fft_start), 32'd0);
    tick();
    check_eq("t1_start", 32'(sif.fft_start), 32'd1);
    sif.ch_req = 2'b00;
    sif.fft_send_done = 1'b1;
    tick();
    sif.fft_send_done = 1'b0;
    check_eq("t1_start_pulse", 32'(sif.fft_start),  32'd0);
    check_eq("t1_fdone_early", 32'(sif.frame_done), 32'd0);
    sif.fft_recv_done = 1'b1;
    tick();
    sif.fft_recv_done = 1'b0;
    check_eq("t1_fdone",      32'(sif.frame_done), 32'd1);
    check_eq("t1_grant_drop", 32'(sif.grant),      32'd0);
    check_eq("t1_idx_kept",   32'(sif.grant_idx),  32'd0);
    tick();
    check_eq("t1_fdone_pulse", 32'(sif.frame_done), 32'd0);
    repeat (2) tick();
    check_eq("t1_gap_busy", 32'(sif.busy), 32'd1);
    tick();
    check_eq("t1_idle_at5", 32'(sif.busy), 32'd0);

    // Alternating grants from reset
    do_reset();
    sif.enable = 1'b1; sif.ch_mask = 2'b11; sif.ch_req = 2'b11;
    run_frame(2'd0, "t2_f0");
    run_frame(2'd1, "t2_f1");
    run_frame(2'd0, "t2_f2");
    run_frame(2'd1, "t2_f3");

    // Masked channel never granted
    do_reset();
    sif.enable = 1'b1; sif.ch_mask = 2'b10; sif.ch_req = 2'b11;
    run_frame(2'd1, "t3_f0");
    run_frame(2'd1, "t3_f1");

    // Watchdog abort, then the other channel owns the next frame
    do_reset();
    sif.enable = 1'b1; sif.ch_mask = 2'b11; sif.ch_req = 2'b11;
    wait_start("t4");
    n = 0;
    while (!sif.fft_abort && n < 200) begin
      tick();
      n++;
    end
    check_eq("t4_abort_cycles", 32'(n),               32'd100);
    check_eq("t4_timeout_err",  32'(sif.timeout_err), 32'd1);
    check_eq("t4_grant_drop",   32'(sif.grant),       32'd0);
    check_eq("t4_no_fdone",     32'(sif.frame_done),  32'd0);
    tick();
    check_eq("t4_abort_pulse", 32'(sif.fft_abort), 32'd0);
    run_frame(2'd1, "t4_next");

    // recv_done on the expiry cycle wins over the watchdog
    wait_start("t5");
    check_eq("t5_idx", 32'(sif.grant_idx), 32'd0);
    sif.fft_send_done = 1'b1;
    tick();
    sif.fft_send_done = 1'b0;
    repeat (98) tick();
    sif.fft_recv_done = 1'b1;
    tick();
    sif.fft_recv_done = 1'b0;
    check_eq("t5_fdone",       32'(sif.frame_done),  32'd1);
    check_eq("t5_no_timeout",  32'(sif.timeout_err), 32'd0);
    check_eq("t5_no_abort",    32'(sif.fft_abort),   32'd0);
    wait_idle("t5");

    // enable dropped mid-frame, then asynchronous reset in RECV
    wait_start("t6");
    sif.enable = 1'b0;
    tick();
    sif.fft_send_done = 1'b1;
    tick();
    sif.fft_send_done = 1'b0;
    sif.fft_recv_done = 1'b1;
    tick();
    sif.fft_recv_done = 1'b0;
    check_eq("t6_fdone", 32'(sif.frame_done), 32'd1);
    n = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (sif.fft_start) n++;
    end
    check_eq("t6_no_start", 32'(n),        32'd0);
    check_eq("t6_idle",     32'(sif.busy), 32'd0);
    sif.ch_mask = 2'b10;
    sif.enable  = 1'b1;
    wait_start("t6_re");
    check_eq("t6_re_idx", 32'(sif.grant_idx), 32'd1);
    sif.fft_send_done = 1'b1;
    tick();
    sif.fft_send_done = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("t6_arst_busy",  32'(sif.busy),      32'd0);
    check_eq("t6_arst_grant", 32'(sif.grant),     32'd0);
    check_eq("t6_arst_idx",   32'(sif.grant_idx), 32'd0);
    check_eq("t6_arst_start", 32'(sif.fft_start), 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
